// File: rtl/clkdiv_ratio_ctrl.sv
// clkdiv_ratio_ctrl: runtime divide-ratio controller; ports clk/rst, run, cfg_valid/cfg_ratio/cfg_ready handshake, div_clk_o, tick_o, upd_done_o, active_o, ratio_o; CLKDIV_SYNC_UPDATE_EN defers ratio updates to period boundaries
module clkdiv_ratio_ctrl #(
  parameter int DIV_W       = 8,
  parameter int RESET_RATIO = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_ratio,
  output logic             cfg_ready,
  output logic             div_clk_o,
  output logic             tick_o,
  output logic             upd_done_o,
  output logic             active_o,
  output logic [DIV_W-1:0] ratio_o
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
`ifdef CLKDIV_SYNC_UPDATE_EN
  localparam bit IMM = 1'b0;
`else
  localparam bit IMM = 1'b1;
`endif
  logic [1:0] state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, act_q, act_d, pend_q, pend_d, clamped;
  logic pend_v_q, pend_v_d, div_q, div_d, upd_q, upd_d;
  logic running, bnd, apply, accept;
  assign running = state_q != IDLE;
  assign bnd     = running && cnt_q == act_q - DIV_W'(1);
  assign apply   = pend_v_q && (!running || bnd || IMM);
  assign accept  = cfg_valid && !pend_v_q;
  assign clamped = cfg_ratio < DIV_W'(2) ? DIV_W'(2) : cfg_ratio;
  always_comb begin
    act_d    = apply ? pend_q : act_q;
    pend_d   = accept ? clamped : pend_q;
    pend_v_d = accept || (pend_v_q && !apply);
    upd_d    = apply;
    cnt_d    = (!running || bnd || apply) ? '0 : cnt_q + DIV_W'(1);
    state_d  = state_q == IDLE ? (run ? RUN : IDLE) :
               state_q == RUN  ? (run ? RUN : DRAIN) :
               run ? RUN : (bnd ? IDLE : DRAIN);
    // derived from next-state values so the registered clock lines up with cnt
    div_d    = state_d != IDLE && cnt_d < act_d - (act_d >> 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      act_q    <= DIV_W'(RESET_RATIO);
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      div_q    <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      act_q    <= act_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      div_q    <= div_d;
      upd_q    <= upd_d;
    end
  end
  assign cfg_ready  = !pend_v_q;
  assign div_clk_o  = div_q;
  assign tick_o     = running && cnt_q == '0;
  assign upd_done_o = upd_q;
  assign active_o   = running;
  assign ratio_o    = act_q;
endmodule

// File: doc/clkdiv_ratio_ctrl.md
# clkdiv_ratio_ctrl

Runtime controller for the project's programmable clock divider. It owns the divide counter, accepts new divide ratios over a valid/ready handshake, and applies them only on a divided-period boundary, so `div_clk_o` never produces a runt pulse. It starts and stops the divided clock cleanly and reports update completion. It sits between the pin-level input decode (ratio from `ui_in`, run bit) and the `uo_out` clock and status pins.

## Interface
- `DIV_W`, 8: width of the ratio and the counter.
- `RESET_RATIO`, 2: active ratio after reset; must be ≥ 2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  level; 1 requests the divided clock to run.
- `cfg_valid`  in  1  a ratio update is offered.
- `cfg_ratio`  in  DIV_W  requested ratio N (divided period = N `clk` cycles).
- `cfg_ready`  out  1  controller can accept an update.
- `div_clk_o`  out  1  divided clock, registered.
- `tick_o`  out  1  one-cycle pulse on each divided-period start.
- `upd_done_o`  out  1  one-cycle pulse when a pending ratio becomes active.
- `active_o`  out  1  divided clock is running (RUN or DRAIN).
- `ratio_o`  out  DIV_W  currently active ratio.

## Operation
- Registers:
  - `state` ∈ {IDLE, RUN, DRAIN}
  - `cnt`: 0..N−1
  - `act` (active ratio)
  - `pend` (pending ratio)
  - `pend_v` (pending flag)
- Ratio clamp: a `cfg_ratio` of 0 or 1 is stored as 2. Any other value is stored unchanged. No other arithmetic limits apply; N up to 2^DIV_W−1.
- Handshake:
  - `cfg_ready = !pend_v`.
  - Accept when `cfg_valid && cfg_ready`.
  - On accept, `pend` ← clamped ratio and `pend_v` ← 1.
  - `cfg_valid` while not ready is held off and is not lost. The requester must hold it.
- Boundary: the clock edge that ends a cycle in which `cnt == act−1` while in RUN or DRAIN.
- IDLE:
  - `cnt` = 0, `div_clk_o` = 0.
  - If `pend_v`, then `act` ← `pend`, `pend_v` ← 0, and `upd_done_o` pulses on the next edge.
  - If `run` = 1, go to RUN.
- RUN:
  - `cnt` increments each cycle and wraps to 0 at a boundary.
  - At a boundary with `pend_v` = 1: `act` ← `pend`, `pend_v` ← 0, and `upd_done_o` pulses in the first cycle of the new period.
  - `run` = 0 → DRAIN.
- DRAIN:
  - Counting continues.
  - At the next boundary, go to IDLE and apply a pending ratio as in RUN.
  - `run` = 1 again before that boundary → RUN with no disturbance to the count.
- `div_clk_o` = 1 while `cnt < act − (act>>1)`, otherwise 0, and only in RUN or DRAIN.
  - N=2: 1 high, 1 low. N=3: 2 high, 1 low. N=4: 2 high, 2 low.
  - Computed from the next-state values and registered, so it is exactly aligned with `cnt`.
- `tick_o` = 1 in the cycles where `cnt` = 0 in RUN or DRAIN.
- `active_o` = 1 when `state` is not IDLE.
- `ratio_o` = `act`.
- Reset mid-operation: returns immediately to IDLE and discards any pending ratio.

## Timing
- Reset values:
  - `state` = IDLE, `cnt` = 0, `act` = `RESET_RATIO`, `pend_v` = 0.
  - `div_clk_o` = 0, `tick_o` = 0, `upd_done_o` = 0, `active_o` = 0.
  - `cfg_ready` = 1, `ratio_o` = `RESET_RATIO`.
- Start: `run` sampled 1 in IDLE at edge t. In cycle t+1: `cnt` = 0, `div_clk_o` = 1, `tick_o` = 1, `active_o` = 1.
- `tick_o` period = `act` cycles.
- Stop: `div_clk_o` last falls per the ratio. `active_o` drops in the cycle after the boundary, and that cycle has `tick_o` = 0.
- Update latency (RUN) is from 1 up to `act` cycles after acceptance.
- An acceptance on the boundary edge itself is not applied at that boundary. It takes effect at the following boundary.
- `cfg_ready` returns to 1 in the same cycle that `upd_done_o` pulses.
- Update latency in IDLE: `upd_done_o` and the new `ratio_o` appear two cycles after the accepting edge.
- Simultaneous `run` 1→0 and a pending update: the update is applied at the drain boundary.

## Configuration
- Macro `CLKDIV_SYNC_UPDATE_EN`.
- Defined (default build): updates are deferred to a period boundary as described above.
- Undefined: in RUN or DRAIN, a pending ratio is applied at the next edge with `cnt` ← 0, restarting the period.
  - `tick_o` and `upd_done_o` pulse in that cycle.
  - The current period may be truncated.
  - `cfg_ready` is 0 for exactly one cycle after acceptance.
  - IDLE behaviour is unchanged.

## Test plan
- Reset, then `run` = 1 with the default ratio → `div_clk_o` toggles 1,0,1,0…; `tick_o` every 2 cycles; `ratio_o` = 2.
- In IDLE, offer `cfg_ratio` = 5, then run → 3 cycles high, 2 low; `tick_o` every 5 cycles; `upd_done_o` pulses once before start.
- Running at N = 4, offer N = 7 when `cnt` = 1 → the current period completes with 4 cycles; the next period is 7 cycles (4 high, 3 low); `cfg_ready` is low until `upd_done_o`.
- Offer the update exactly when `cnt` = `act`−1 → one further old-ratio period, then the new ratio; a second `cfg_valid` while `cfg_ready` = 0 is stalled until then.
- Offer `cfg_ratio` = 0 and `cfg_ratio` = 1 → `ratio_o` = 2. Drop `run` mid-period at N = 6 → the period finishes, then IDLE with `div_clk_o` = 0 and `active_o` = 0. Re-raise `run` during DRAIN → no gap.
- Assert `rst` mid-period with an update pending → next cycle all outputs at reset values and `cfg_ready` = 1. Under an undefined `CLKDIV_SYNC_UPDATE_EN`, an update at `cnt` = 1 restarts the period immediately.
